iir_biquad_cascade: RTL and testbench
=====================================

IIR_BIQUAD_CASCADE -- requirements
Module: iir_biquad_cascade

Interface
REQ-001 SHALL provide parameter COEFF_WIDTH, default 18, signed coefficient width.
REQ-002 SHALL provide parameter COEFF_SCALE, default 14, coefficient fractional bits.
REQ-003 SHALL provide parameter DATA_WIDTH, default 16, signed sample width.
REQ-004 SHALL provide parameter STAGES, default 2, number of cascaded 2nd-order sections (1..8).
REQ-005 SHALL provide parameter COUNT_BITS, default 10, sample-divider width.
REQ-006 SHALL provide ports:
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- div  in  COUNT_BITS  sample period in clk cycles.
- coef_we  in  1  shadow coefficient write strobe.
- coef_addr  in  ceil(log2(5*STAGES))  index = stage*5 + k; k: 0=B1, 1=B2, 2=B3, 3=A2, 4=A3.
- coef_data  in  COEFF_WIDTH  signed coefficient value.
- coef_commit  in  1  request shadow-to-active copy.
- in  in  DATA_WIDTH  signed input sample.
- out  out  DATA_WIDTH  signed filtered sample.
- out_valid  out  1  one-cycle pulse on each out update.
- overrun  out  1  sticky; sample tick arrived while busy.
- sat  out  1  sticky; any stage output clipped.

Function
REQ-007 SHALL generate a sample tick when the free-running divider count equals div-1, then clear the count; div=0 SHALL be treated as div=1.
REQ-008 SHALL use exactly one COEFF_WIDTH x DATA_WIDTH multiplier, time-multiplexed, plus an accumulator of DATA_WIDTH+COEFF_WIDTH+3 bits.
REQ-009 SHALL implement FSM states IDLE -> MAC -> STORE -> (MAC for next stage | IDLE after last stage).
REQ-010 On tick in IDLE: capture in as stage-0 x0, shift stage-0 x history, clear accumulator, enter MAC for stage 0.
REQ-011 MAC SHALL take 5 cycles per stage, one product per cycle, ordered B1*x0, B2*x1, B3*x2, -A2*y0, -A3*y1.
REQ-012 STORE SHALL form y = acc >>> COEFF_SCALE (arithmetic, truncating) and saturate it to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; on clip, set sat.
REQ-013 STORE SHALL shift the stage's y history (y1<=y0, y0<=y), feed y as x0 of the next stage with that stage's x history shifted, and clear the accumulator.
REQ-014 After the last stage's STORE, out SHALL equal that stage's y and out_valid SHALL pulse in the same cycle; latency from tick to out_valid is 6*STAGES cycles (12 at default).
REQ-015 out SHALL hold its value between updates.
REQ-016 Tick while not IDLE SHALL be dropped (in is not captured, histories unchanged), overrun SHALL be set, and the current computation SHALL continue unaffected.
REQ-017 coef_we SHALL write coef_data to the shadow bank at coef_addr in any state; addresses >= 5*STAGES SHALL be ignored.
REQ-018 coef_commit SHALL be latched; the pending copy SHALL execute on the next tick accepted from IDLE, before the first MAC cycle, so one sample never mixes coefficient sets.
REQ-019 coef_we and coef_commit in the same cycle SHALL include that write in the committed set.
REQ-020 Filter state SHALL persist across commits; commits SHALL NOT clear histories.

Reset
REQ-021 reset SHALL clear the divider count, all x/y histories, the accumulator, out, out_valid, overrun, sat, and the pending commit, and SHALL force IDLE.
REQ-022 reset SHALL clear both coefficient banks to 0, so out stays 0 until coefficients are committed.
REQ-023 reset asserted mid-MAC SHALL abort the computation with no out_valid pulse; the first tick after release is processed normally.

Verification
REQ-024 Pass-through: STAGES=2, both stages B1=16384, others 0, commit, div=20, in=1000 -> within two ticks, out=1000 with out_valid 12 cycles after the accepted tick.
REQ-025 Low-pass DC: stage 0 B=(1183,2367,1183), A2=-18174, A3=6523; stage 1 pass-through; in=10000 constant -> out settles to 10000 +/-4, no sat.
REQ-026 Saturation: stage 0 B1=32767, in=20000 -> out=32767, sat=1; in=-20000 -> out=-32768.
REQ-027 Overrun: STAGES=2, div=5 -> overrun=1 after the second tick; every out_valid still carries a correctly computed sample.
REQ-028 Commit timing: write gain 0.5 (B1=8192) while busy and assert coef_commit -> current sample uses the old gain; next sample uses 0.5 (in=1000 -> out=500).
REQ-029 Reset mid-MAC: assert reset 3 cycles after a tick -> no out_valid pulse; out=0, overrun=0, sat=0, FSM in IDLE.

Source files
------------

// File: rtl/iir_biquad_cascade_if.sv
// Sample stream, coefficient write bus and status flags of the biquad cascade.
// The master side drives samples and coefficients; the slave side is the filter.
interface iir_biquad_cascade_if #(
    parameter int COEFF_WIDTH = 18,
    parameter int DATA_WIDTH  = 16,
    parameter int STAGES      = 2,
    parameter int COUNT_BITS  = 10
);
    localparam int ADDR_WIDTH = $clog2(5 * STAGES);

    logic [COUNT_BITS-1:0]         div;
    logic                          coef_we;
    logic [ADDR_WIDTH-1:0]         coef_addr;
    logic signed [COEFF_WIDTH-1:0] coef_data;
    logic                          coef_commit;
    logic signed [DATA_WIDTH-1:0]  in;
    logic signed [DATA_WIDTH-1:0]  out;
    logic                          out_valid;
    logic                          overrun;
    logic                          sat;

    modport master (
        output div, coef_we, coef_addr, coef_data, coef_commit, in,
        input  out, out_valid, overrun, sat
    );

    modport slave (
        input  div, coef_we, coef_addr, coef_data, coef_commit, in,
        output out, out_valid, overrun, sat
    );
endinterface

// File: rtl/iir_biquad_cascade.sv
// Cascade of direct-form-I biquads sharing one multiplier, with a shadow/active
// coefficient bank swapped only at sample boundaries.
module iir_biquad_cascade #(
    parameter int COEFF_WIDTH = 18,
    parameter int COEFF_SCALE = 14,
    parameter int DATA_WIDTH  = 16,
    parameter int STAGES      = 2,
    parameter int COUNT_BITS  = 10
) (
    input logic                 clk,
    input logic                 reset,
    iir_biquad_cascade_if.slave bus
);
    localparam int NCOEF   = 5 * STAGES;
    localparam int ADDR_W  = $clog2(NCOEF);
    localparam int STAGE_W = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam int PROD_W  = COEFF_WIDTH + DATA_WIDTH;
    localparam int ACC_W   = PROD_W + 3;
    localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(STAGES - 1);

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        STORE
    } state_t;

    state_t                        state_reg;
    logic [STAGE_W-1:0]            stage_reg;
    logic [2:0]                    mac_reg;
    logic signed [ACC_W-1:0]       acc_reg;
    logic [COUNT_BITS-1:0]         cnt_reg;
    logic                          pending_reg;
    logic signed [DATA_WIDTH-1:0]  out_reg;
    logic                          out_valid_reg;
    logic                          overrun_reg;
    logic                          sat_reg;

    logic signed [COEFF_WIDTH-1:0] active_w [NCOEF];
    logic signed [DATA_WIDTH-1:0]  x0_w [STAGES];
    logic signed [DATA_WIDTH-1:0]  x1_w [STAGES];
    logic signed [DATA_WIDTH-1:0]  x2_w [STAGES];
    logic signed [DATA_WIDTH-1:0]  y0_w [STAGES];
    logic signed [DATA_WIDTH-1:0]  y1_w [STAGES];

    logic [COUNT_BITS-1:0]         div_eff;
    logic                          tick;
    logic                          accept;
    logic                          store_fire;
    logic                          commit_now;

    logic [ADDR_W-1:0]             coef_idx;
    logic signed [COEFF_WIDTH-1:0] coef_sel;
    logic signed [DATA_WIDTH-1:0]  data_sel;
    logic signed [PROD_W-1:0]      prod;
    logic signed [ACC_W-1:0]       prod_ext;

    logic signed [ACC_W-1:0]       acc_shift;
    logic [ACC_W-DATA_WIDTH:0]     acc_hi;
    logic                          y_clip;
    logic signed [DATA_WIDTH-1:0]  y_sat;

    // Sample-rate divider; a zero divisor behaves like one (tick every cycle).
    assign div_eff    = (bus.div == '0) ? COUNT_BITS'(1) : bus.div;
    assign tick       = (cnt_reg == div_eff - COUNT_BITS'(1));
    assign accept     = (state_reg == IDLE) && tick;
    assign store_fire = (state_reg == STORE);
    assign commit_now = accept && (pending_reg || bus.coef_commit);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (tick) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + COUNT_BITS'(1);
        end
    end

    // Coefficient banks. The copy source includes a write landing in the same
    // cycle, so a write issued together with its commit is never lost.
    generate
        for (genvar gi = 0; gi < NCOEF; gi++) begin : g_coef
            logic                          hit;
            logic signed [COEFF_WIDTH-1:0] shadow_next;
            logic signed [COEFF_WIDTH-1:0] shadow_reg;
            logic signed [COEFF_WIDTH-1:0] active_reg;

            assign hit         = bus.coef_we && (bus.coef_addr == ADDR_W'(gi));
            assign shadow_next = hit ? bus.coef_data : shadow_reg;
            assign active_w[gi] = active_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    shadow_reg <= '0;
                    active_reg <= '0;
                end else begin
                    shadow_reg <= shadow_next;
                    if (commit_now) begin
                        active_reg <= shadow_next;
                    end
                end
            end
        end
    endgenerate

    // Per-stage delay lines: stage 0 shifts on an accepted tick, later stages
    // shift when the previous stage stores its output.
    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            logic                         shift_x;
            logic                         shift_y;
            logic signed [DATA_WIDTH-1:0] x_new;
            logic signed [DATA_WIDTH-1:0] x0_reg;
            logic signed [DATA_WIDTH-1:0] x1_reg;
            logic signed [DATA_WIDTH-1:0] x2_reg;
            logic signed [DATA_WIDTH-1:0] y0_reg;
            logic signed [DATA_WIDTH-1:0] y1_reg;

            if (gi == 0) begin : g_first
                assign shift_x = accept;
                assign x_new   = bus.in;
            end else begin : g_rest
                assign shift_x = store_fire && (stage_reg == STAGE_W'(gi - 1));
                assign x_new   = y_sat;
            end
            assign shift_y = store_fire && (stage_reg == STAGE_W'(gi));

            always_ff @(posedge clk) begin
                if (reset) begin
                    x0_reg <= '0;
                    x1_reg <= '0;
                    x2_reg <= '0;
                    y0_reg <= '0;
                    y1_reg <= '0;
                end else begin
                    if (shift_x) begin
                        x2_reg <= x1_reg;
                        x1_reg <= x0_reg;
                        x0_reg <= x_new;
                    end
                    if (shift_y) begin
                        y1_reg <= y0_reg;
                        y0_reg <= y_sat;
                    end
                end
            end

            assign x0_w[gi] = x0_reg;
            assign x1_w[gi] = x1_reg;
            assign x2_w[gi] = x2_reg;
            assign y0_w[gi] = y0_reg;
            assign y1_w[gi] = y1_reg;
        end
    endgenerate

    // Shared multiplier: mac_reg picks the tap, the coefficient index follows
    // the bank layout stage*5 + k.
    assign coef_idx = ADDR_W'(32'(stage_reg) * 32'd5 + 32'(mac_reg));
    assign coef_sel = active_w[coef_idx];

    always_comb begin
        data_sel = x0_w[stage_reg];
        case (mac_reg)
            3'd1:    data_sel = x1_w[stage_reg];
            3'd2:    data_sel = x2_w[stage_reg];
            3'd3:    data_sel = y0_w[stage_reg];
            3'd4:    data_sel = y1_w[stage_reg];
            default: data_sel = x0_w[stage_reg];
        endcase
    end

    assign prod     = PROD_W'(coef_sel) * PROD_W'(data_sel);
    assign prod_ext = {{3{prod[PROD_W-1]}}, prod};

    // Rescale and clip: any disagreement among the bits above the output sign
    // bit means the value does not fit in DATA_WIDTH.
    assign acc_shift = acc_reg >>> COEFF_SCALE;
    assign acc_hi    = acc_shift[ACC_W-1:DATA_WIDTH-1];
    assign y_clip    = !((&acc_hi) || !(|acc_hi));
    assign y_sat     = !y_clip ? acc_shift[DATA_WIDTH-1:0] :
                       acc_shift[ACC_W-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} :
                                            {1'b0, {(DATA_WIDTH-1){1'b1}}};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            stage_reg     <= '0;
            mac_reg       <= '0;
            acc_reg       <= '0;
            pending_reg   <= 1'b0;
            out_reg       <= '0;
            out_valid_reg <= 1'b0;
            overrun_reg   <= 1'b0;
            sat_reg       <= 1'b0;
        end else begin
            out_valid_reg <= 1'b0;
            if (accept) begin
                pending_reg <= 1'b0;
            end else if (bus.coef_commit) begin
                pending_reg <= 1'b1;
            end
            if (tick && (state_reg != IDLE)) begin
                overrun_reg <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    if (tick) begin
                        acc_reg   <= '0;
                        stage_reg <= '0;
                        mac_reg   <= '0;
                        state_reg <= MAC;
                    end
                end
                MAC: begin
                    // Feedback taps (A2, A3) are subtracted rather than negated.
                    if (mac_reg >= 3'd3) begin
                        acc_reg <= acc_reg - prod_ext;
                    end else begin
                        acc_reg <= acc_reg + prod_ext;
                    end
                    if (mac_reg == 3'd4) begin
                        mac_reg   <= '0;
                        state_reg <= STORE;
                    end else begin
                        mac_reg <= mac_reg + 3'd1;
                    end
                end
                STORE: begin
                    acc_reg <= '0;
                    if (y_clip) begin
                        sat_reg <= 1'b1;
                    end
                    if (stage_reg == LAST_STAGE) begin
                        out_reg       <= y_sat;
                        out_valid_reg <= 1'b1;
                        state_reg     <= IDLE;
                    end else begin
                        stage_reg <= stage_reg + STAGE_W'(1);
                        state_reg <= MAC;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.out       = out_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.overrun   = overrun_reg;
    assign bus.sat       = sat_reg;
endmodule

// File: tb/tb_iir_biquad_cascade.sv
// Scoreboard bench: a reference cascade predicts every sample at the accepting tick
// and each out_valid is checked for value, latency and sticky flags.
module tb_iir_biquad_cascade;
    localparam int CW     = 18;
    localparam int CS     = 14;
    localparam int DW     = 16;
    localparam int STAGES = 2;
    localparam int CB     = 10;
    localparam int NCOEF  = 5 * STAGES;
    localparam int AW     = $clog2(NCOEF);
    localparam int LAT    = 6 * STAGES;
    localparam longint YMAX = 32767;
    localparam longint YMIN = -32768;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    iir_biquad_cascade_if #(.COEFF_WIDTH(CW), .DATA_WIDTH(DW), .STAGES(STAGES), .COUNT_BITS(CB)) bus ();

    iir_biquad_cascade #(
        .COEFF_WIDTH(CW), .COEFF_SCALE(CS), .DATA_WIDTH(DW), .STAGES(STAGES), .COUNT_BITS(CB)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic signed [DW-1:0] val;
        int                   due;
        logic                 sat;
    } exp_t;

    exp_t   sb[$];
    int     n_checks = 0;
    int     n_fail = 0;
    int     cyc = 0;
    int     n_outs = 0;
    int     m_cnt, m_busy;
    logic   m_pend, m_ovr, m_sat, m_accepted;
    longint m_shadow[NCOEF];
    longint m_active[NCOEF];
    longint mx[STAGES][3];
    longint my[STAGES][2];

    task automatic model_reset();
        m_cnt = 0; m_busy = 0; m_pend = 0; m_ovr = 0; m_sat = 0; m_accepted = 0;
        for (int i = 0; i < NCOEF; i++) begin
            m_shadow[i] = 0;
            m_active[i] = 0;
        end
        for (int s = 0; s < STAGES; s++) begin
            mx[s][0] = 0; mx[s][1] = 0; mx[s][2] = 0;
            my[s][0] = 0; my[s][1] = 0;
        end
        sb.delete();
    endtask

    function automatic logic signed [DW-1:0] model_sample(longint xin);
        longint v, acc, y;
        v = xin;
        for (int s = 0; s < STAGES; s++) begin
            mx[s][2] = mx[s][1];
            mx[s][1] = mx[s][0];
            mx[s][0] = v;
            acc = m_active[5*s] * mx[s][0] + m_active[5*s+1] * mx[s][1] + m_active[5*s+2] * mx[s][2]
                - m_active[5*s+3] * my[s][0] - m_active[5*s+4] * my[s][1];
            y = acc >>> CS;
            if (y > YMAX) begin
                y = YMAX; m_sat = 1;
            end else if (y < YMIN) begin
                y = YMIN; m_sat = 1;
            end
            my[s][1] = my[s][0];
            my[s][0] = y;
            v = y;
        end
        return DW'(v);
    endfunction

    // Predict the upcoming edge, advance one clock, then check the outputs.
    task automatic step();
        int   de;
        logic tk;
        exp_t e;
        m_accepted = 0;
        if (reset) begin
            model_reset();
        end else begin
            de = (bus.div == '0) ? 1 : int'(bus.div);
            tk = (m_cnt == de - 1);
            if (bus.coef_we && int'(bus.coef_addr) < NCOEF) m_shadow[bus.coef_addr] = longint'(bus.coef_data);
            if (tk && m_busy == 0) begin
                if (m_pend || bus.coef_commit) m_active = m_shadow;
                m_pend = 0;
                e.val = model_sample(longint'(bus.in));
                e.due = cyc + 1 + LAT;
                e.sat = m_sat;
                sb.push_back(e);
                m_busy = LAT;
                m_accepted = 1;
            end else begin
                if (tk) m_ovr = 1;
                if (m_busy > 0) m_busy--;
                if (bus.coef_commit) m_pend = 1;
            end
            m_cnt = tk ? 0 : ((m_cnt + 1) & ((1 << CB) - 1));
        end
        @(posedge clk);
        #1;
        cyc++;
        if (bus.out_valid) begin
            n_outs++;
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_out_valid: pulse at cycle %0d with out=%0d, required no pulse", cyc, bus.out);
            end else begin
                e = sb.pop_front();
                if (bus.out !== e.val || cyc != e.due) begin
                    n_fail++;
                    $display("FAIL sample: out=%0d at cycle %0d, required %0d at cycle %0d", bus.out, cyc, e.val, e.due);
                end
                n_checks++;
                if (bus.sat !== e.sat || bus.overrun !== m_ovr) begin
                    n_fail++;
                    $display("FAIL flags: sat=%b overrun=%b, required sat=%b overrun=%b", bus.sat, bus.overrun, e.sat, m_ovr);
                end
                $display("cycle %0d: out=%0d sat=%b overrun=%b", cyc, bus.out, bus.sat, bus.overrun);
            end
        end else if (sb.size() != 0 && sb[0].due <= cyc) begin
            n_checks++;
            n_fail++;
            $display("FAIL missing_out_valid: no pulse at cycle %0d, required out=%0d", cyc, sb[0].val);
            void'(sb.pop_front());
        end
    endtask

    task automatic do_reset();
        bus.coef_we = 0;
        bus.coef_commit = 0;
        reset = 1;
        step();
        step();
        reset = 0;
    endtask

    task automatic write_coef(input int addr, input int data, input logic commit);
        bus.coef_addr = AW'(addr);
        bus.coef_data = CW'(data);
        bus.coef_we = 1;
        bus.coef_commit = commit;
        step();
        bus.coef_we = 0;
        bus.coef_commit = 0;
    endtask

    task automatic load_passthrough();
        write_coef(0, 16384, 0);
        write_coef(5, 16384, 1);
    endtask

    task automatic run_outputs(input string name, input int n, input int budget, input logic rnd);
        int target, k;
        target = n_outs + n;
        k = 0;
        while (n_outs < target && k < budget) begin
            if (rnd) bus.in = DW'($urandom_range(0, 65535));
            step();
            k++;
        end
        if (n_outs < target) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: %0d outputs seen, required %0d within %0d cycles", name, n_outs - target + n, n, budget);
        end
    endtask

    task automatic wait_accept(input string name, input int budget);
        int k;
        k = 0;
        m_accepted = 0;
        while (!m_accepted && k < budget) begin
            step();
            k++;
        end
        if (!m_accepted) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_accept_timeout: no tick accepted, required one within %0d cycles", name, budget);
        end
    endtask

    task automatic test_reset();
        bus.div = 20;
        do_reset();
        n_checks += 4;
        if (bus.out !== 16'sd0) begin n_fail++; $display("FAIL reset_out: out=%0d, required 0", bus.out); end
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: %b, required 0", bus.out_valid); end
        if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: %b, required 0", bus.overrun); end
        if (bus.sat !== 1'b0) begin n_fail++; $display("FAIL reset_sat: %b, required 0", bus.sat); end
        bus.in = 16'sd1000;
        run_outputs("zero_coef", 1, 100, 0);
    endtask

    task automatic test_passthrough();
        bus.div = 20;
        do_reset();
        load_passthrough();
        write_coef(12, 777, 0);
        bus.in = 16'sd1000;
        run_outputs("passthrough", 2, 100, 0);
        n_checks++;
        if (bus.out !== 16'sd1000) begin n_fail++; $display("FAIL passthrough_out: out=%0d, required 1000", bus.out); end
        run_outputs("passthrough_random", 4, 200, 1);
    endtask

    task automatic test_saturation();
        bus.div = 20;
        do_reset();
        write_coef(0, 32767, 0);
        write_coef(5, 16384, 1);
        bus.in = 16'sd20000;
        run_outputs("sat_pos", 2, 100, 0);
        n_checks += 2;
        if (bus.out !== 16'sd32767) begin n_fail++; $display("FAIL sat_pos_out: out=%0d, required 32767", bus.out); end
        if (bus.sat !== 1'b1) begin n_fail++; $display("FAIL sat_flag: sat=%b, required 1", bus.sat); end
        bus.in = -16'sd20000;
        run_outputs("sat_neg", 2, 100, 0);
        n_checks++;
        if (bus.out !== -16'sd32768) begin n_fail++; $display("FAIL sat_neg_out: out=%0d, required -32768", bus.out); end
    endtask

    task automatic test_lowpass();
        int d;
        bus.div = 13;
        do_reset();
        write_coef(0, 1183, 0);
        write_coef(1, 2367, 0);
        write_coef(2, 1183, 0);
        write_coef(3, -18174, 0);
        write_coef(4, 6523, 0);
        write_coef(5, 16384, 1);
        bus.in = 16'sd10000;
        run_outputs("lowpass", 60, 2000, 0);
        d = int'(bus.out) - 10000;
        n_checks += 2;
        if (d > 4 || d < -4) begin n_fail++; $display("FAIL lowpass_dc: out=%0d, required 10000 +/-4", bus.out); end
        if (bus.sat !== 1'b0) begin n_fail++; $display("FAIL lowpass_sat: sat=%b, required 0", bus.sat); end
    endtask

    task automatic test_overrun();
        bus.div = 5;
        do_reset();
        load_passthrough();
        run_outputs("overrun", 4, 400, 1);
        n_checks++;
        if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_flag: overrun=%b, required 1", bus.overrun); end
    endtask

    task automatic test_div_zero();
        bus.div = 0;
        do_reset();
        load_passthrough();
        run_outputs("div_zero", 4, 200, 1);
    endtask

    task automatic test_commit_timing();
        bus.div = 20;
        do_reset();
        load_passthrough();
        bus.in = 16'sd1000;
        run_outputs("commit_pre", 1, 100, 0);
        wait_accept("commit", 50);
        write_coef(0, 8192, 1);
        run_outputs("commit_old", 1, 100, 0);
        n_checks++;
        if (bus.out !== 16'sd1000) begin n_fail++; $display("FAIL commit_old_gain: out=%0d, required 1000", bus.out); end
        run_outputs("commit_new", 1, 100, 0);
        n_checks++;
        if (bus.out !== 16'sd500) begin n_fail++; $display("FAIL commit_new_gain: out=%0d, required 500", bus.out); end
    endtask

    task automatic test_reset_mid_mac();
        bus.div = 5;
        do_reset();
        write_coef(0, 32767, 0);
        write_coef(5, 16384, 1);
        bus.in = 16'sd20000;
        run_outputs("mid_pre", 2, 200, 0);
        wait_accept("mid", 50);
        step();
        step();
        reset = 1;
        step();
        reset = 0;
        n_checks += 4;
        if (bus.out !== 16'sd0) begin n_fail++; $display("FAIL mid_reset_out: out=%0d, required 0", bus.out); end
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid: %b, required 0", bus.out_valid); end
        if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL mid_reset_overrun: %b, required 0", bus.overrun); end
        if (bus.sat !== 1'b0) begin n_fail++; $display("FAIL mid_reset_sat: %b, required 0", bus.sat); end
        load_passthrough();
        bus.in = 16'sd1234;
        run_outputs("mid_post", 2, 200, 0);
        n_checks++;
        if (bus.out !== 16'sd1234) begin n_fail++; $display("FAIL mid_post_out: out=%0d, required 1234", bus.out); end
    endtask

    initial begin
        bus.div = 20;
        bus.coef_we = 0;
        bus.coef_addr = '0;
        bus.coef_data = '0;
        bus.coef_commit = 0;
        bus.in = '0;
        model_reset();
        test_reset();
        test_passthrough();
        test_saturation();
        test_lowpass();
        test_overrun();
        test_div_zero();
        test_commit_timing();
        test_reset_mid_mac();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
